// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared types and round-robin helper for the FIR channel scheduler
package fir_sched_pkg;

  localparam int CH_IDX_W = 4;
  localparam int MAX_CH   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_HI = 2'd1,
    ISSUE_LO = 2'd2
  } sched_state_e;

  // First requesting channel searching upward from last+1, wrapping at n.
  function automatic logic [CH_IDX_W-1:0] rr_next_grant(
    input logic [MAX_CH-1:0]   req,
    input logic [CH_IDX_W-1:0] last,
    input int                  n
  );
    logic [CH_IDX_W-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = (int'(last) + i) % n;
      if (i <= n && !found && req[idx[CH_IDX_W-1:0]]) begin
        g     = idx[CH_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fir_sched_fifo.sv
// rtl/fir_sched_fifo.sv - per-channel single-clock FIFO; a write to a full FIFO is
// accepted when a pop happens in the same cycle.
module fir_sched_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              wr_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem[rd_ptr_q];
  assign wr_ok     = wr_i && (!full_o || pop_i);
  assign pop_ok    = pop_i && !empty_o;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fir_ch_scheduler.sv
// rtl/fir_ch_scheduler.sv - round-robin issue of per-channel samples to a shared FIR.
// Optional per-channel drop counters built when FIR_SCHED_OVF_CNT_EN is defined.
module fir_ch_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int VALID_HIGH  = 2,
  parameter int SLOT_CYCLES = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_CH*DATA_W-1:0] In_Data,
  input  logic [NUM_CH-1:0]        In_Valid,
  input  logic                     Fir_Ready,
  output logic [DATA_W-1:0]        Fir_Data_In,
  output logic                     Fir_Data_In_Valid,
  output logic [CH_IDX_W-1:0]      Fir_Data_In_ChIdx,
  output logic [NUM_CH-1:0]        Ovf_Flag,
  input  logic                     Ovf_Clr,
  output logic [NUM_CH*8-1:0]      Ovf_Cnt
);

  localparam int CNT_W = $clog2(SLOT_CYCLES + 1);

  sched_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CH_IDX_W-1:0] idx_q, idx_d, last_q, last_d, grant_idx;
  logic [NUM_CH-1:0]   ovf_q, ovf, empty, full, pop;
  logic [MAX_CH-1:0]   req;
  logic [DATA_W-1:0]   rd_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    fir_sched_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK      (CLK),
      .nRST     (nRST),
      .wr_i     (In_Valid[c]),
      .wr_data_i(In_Data[c*DATA_W +: DATA_W]),
      .pop_i    (pop[c]),
      .rd_data_o(rd_data[c]),
      .full_o   (full[c]),
      .empty_o  (empty[c])
    );
  end

  assign ovf = In_Valid & full & ~pop;

  always_comb begin
    req               = '0;
    req[NUM_CH-1:0]   = ~empty;
    grant_idx         = rr_next_grant(req, last_q, NUM_CH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pop     = '0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (Fir_Ready && |(~empty)) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == CH_IDX_W'(c)) begin
              pop[c] = 1'b1;
              data_d = rd_data[c];
            end
          end
          idx_d   = grant_idx;
          last_d  = grant_idx;
          cnt_d   = CNT_W'(1);
          state_d = ISSUE_HI;
        end
      end
      ISSUE_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q <= CNT_W'(VALID_HIGH)) begin
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
          state_d = ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        valid_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        // Slot counts from the grant cycle, so the next grant lands one slot later.
        if (cnt_d >= CNT_W'(SLOT_CYCLES)) state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= CH_IDX_W'(NUM_CH - 1);
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ovf_q   <= (ovf_q & ~{NUM_CH{Ovf_Clr}}) | ovf;
    end
  end

  assign Fir_Data_In       = data_q;
  assign Fir_Data_In_Valid = valid_q;
  assign Fir_Data_In_ChIdx = idx_q;
  assign Ovf_Flag          = ovf_q;

`ifdef FIR_SCHED_OVF_CNT_EN
  logic [7:0] ovf_cnt_q [NUM_CH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < NUM_CH; c++) ovf_cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (Ovf_Clr)
          ovf_cnt_q[c] <= {7'd0, ovf[c]};
        else if (ovf[c] && ovf_cnt_q[c] != 8'hFF)
          ovf_cnt_q[c] <= ovf_cnt_q[c] + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    assign Ovf_Cnt[c*8 +: 8] = ovf_cnt_q[c];
  end
`else
  assign Ovf_Cnt = '0;
`endif

endmodule

// File: doc/fir_ch_scheduler.md
Name: fir_ch_scheduler

Overview:
- Round-robin scheduler that shares one multichannel FIR datapath between up to NUM_CH DDC channel streams.
- Each channel's samples go into a small per-channel FIFO. One sample per slot is issued to the FIR as a timed valid pulse with a stable channel index; the FIR captures on the falling edge of that pulse.
- Issue is gated by FIR readiness, which is low while the FIR is being configured.
- Sits between the DDC decimator outputs and the FIR input port.

Parameters:
- NUM_CH, 4, number of requesting channels (1..16).
- DATA_W, 24, sample width in bits.
- FIFO_DEPTH, 4, entries per channel FIFO; power of 2, at least 2.
- VALID_HIGH, 2, cycles Fir_Data_In_Valid is held high per issue; at least 1.
- SLOT_CYCLES, 16, minimum cycles from one issue's rising edge to the next; must exceed VALID_HIGH and cover FIR compute time.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset.
- In_Data  in  NUM_CH*DATA_W  packed channel samples; channel c occupies bits [c*DATA_W +: DATA_W].
- In_Valid  in  NUM_CH  per-channel single-cycle write strobe.
- Fir_Ready  in  1  high when the FIR is in normal run state.
- Fir_Data_In  out  DATA_W  sample to the FIR.
- Fir_Data_In_Valid  out  1  issue pulse; the FIR captures on its falling edge.
- Fir_Data_In_ChIdx  out  4  channel index of the issued sample.
- Ovf_Flag  out  NUM_CH  sticky per-channel overflow flag.
- Ovf_Clr  in  1  synchronous clear of Ovf_Flag (and of the counters when the optional feature is enabled).
- Ovf_Cnt  out  NUM_CH*8  per-channel drop counters (optional feature).

Behaviour:
- Reset: nRST is asynchronous, active-low; clock is CLK.
  - Reset clears: all outputs, FIFO pointers and levels, the round-robin pointer, the slot counter and Ovf_Flag.
  - The round-robin pointer resets so that channel 0 has highest priority first.
  - State after reset is IDLE.
  - Reset asserted mid-slot aborts the slot immediately; Fir_Data_In_Valid goes low asynchronously.
- FIFO write:
  - In_Valid[c] writes In_Data slice c into FIFO c on that clock edge.
  - Write to a full FIFO with no pop in the same cycle: sample dropped, Ovf_Flag[c] set.
  - Write to a full FIFO in the same cycle as its pop: write accepted.
  - Ovf_Clr and a new overflow in the same cycle: the flag stays set.
- State machine (states IDLE, ISSUE_HI, ISSUE_LO):
  - IDLE: if Fir_Ready=1 and any FIFO is non-empty, grant the first non-empty channel searching from (last_grant+1) mod NUM_CH.
    - On grant, pop that FIFO and register Fir_Data_In and Fir_Data_In_ChIdx.
    - Assert Fir_Data_In_Valid on the next edge, load the slot counter, go to ISSUE_HI.
  - ISSUE_HI: hold Valid high for VALID_HIGH cycles, then drive it low and go to ISSUE_LO.
  - ISSUE_LO: Valid stays low until the slot counter reaches SLOT_CYCLES, then return to IDLE.
  - Fir_Data_In and Fir_Data_In_ChIdx stay stable from the Valid rising edge to the end of the slot.
- Latency: with empty FIFOs, IDLE state and Fir_Ready=1, In_Valid[c] at edge t gives Fir_Data_In_Valid=1 after edge t+2.
- Back-to-back issues: rising edges exactly SLOT_CYCLES apart when requests are continuous.
- Fir_Ready falling:
  - During a slot: the slot completes normally.
  - In IDLE: no new grant is made; FIFO contents are retained and writes continue.
- Fairness: with all channels continuously non-empty, grant order is 0,1,…,NUM_CH-1,0,….
- Channel indices are zero-extended to 4 bits.

Optional Feature:
- Macro FIR_SCHED_OVF_CNT_EN.
- Defined: Ovf_Cnt[c] is an 8-bit counter incremented per dropped sample. It saturates at 255 and is cleared by Ovf_Clr.
- Undefined: Ovf_Cnt is tied to 0 and no counter logic is built.
- Ovf_Flag behaviour is identical either way.

Decomposition:
- Package fir_sched_pkg holds:
  - CH_IDX_W=4;
  - the state encoding (IDLE, ISSUE_HI, ISSUE_LO);
  - a round-robin next-grant function.
- Sub-module fir_sched_fifo: single-clock FIFO with write, pop, full, empty and same-cycle full write+pop. One instance per channel via generate.

Test Plan:
- Single sample: 0x123456 on ch2, Fir_Ready=1.
  - Valid high at t+2 for 2 cycles.
  - ChIdx=2, Data=0x123456, held for 16 cycles.
- All 4 channels strobed together.
  - Issues at 16-cycle spacing in order 0,1,2,3.
  - Each with the correct data.
- 5 writes to ch1 while Fir_Ready=0.
  - 5th write dropped, Ovf_Flag=4'b0010.
  - With the feature on, Ovf_Cnt[1]=1.
  - After Fir_Ready=1, the first four samples are issued in order; Ovf_Clr then clears the flag.
- Fir_Ready drops in cycle 3 of a slot.
  - The slot finishes.
  - No further Valid until Fir_Ready=1, even with a pending sample.
- Full FIFO with simultaneous write and pop.
  - Write accepted, no overflow flag.
- nRST asserted during ISSUE_HI.
  - Valid low immediately, all FIFOs empty.
  - After release, the first grant goes to ch0.
